// File: rtl/hazard_fwd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl_pkg
//   Shared definitions for the pipeline hazard / forwarding controller.
//   - FWD_* : encodings of the EX-stage 3:1 operand mux select.
//   - sb_flags_t : per-stage scoreboard status bits (the destination index is
//     carried next to it so its width can follow the REG_W parameter).
//   - fwd_pick : forwarding priority helper (younger producer wins).
// ---------------------------------------------------------------------------
package hazard_fwd_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM result

  typedef struct packed {
    logic valid;     // stage holds a real instruction
    logic regwrite;  // instruction writes its destination
    logic memread;   // instruction is a load
  } sb_flags_t;

  localparam int SB_FLAGS_W = $bits(sb_flags_t);

  // Producer one ahead (in EX while the consumer is in ID) is the younger one
  // and therefore holds the architecturally newest value.
  function automatic logic [1:0] fwd_pick(input logic match_ex, input logic match_mem);
    logic [1:0] sel;
    sel = FWD_REG;
    if (match_ex) begin
      sel = FWD_MEM;
    end else if (match_mem) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// ---------------------------------------------------------------------------
// hazard_sb_stage
//   One stage of the destination-register scoreboard shift chain.
//   Ports:
//     clk, reset       : core clock, synchronous active-high reset
//     bubble           : load an empty entry instead of d_* this cycle
//     d_flags, d_dest  : entry arriving from the previous stage
//     q_flags, q_dest  : entry currently held by this stage
// ---------------------------------------------------------------------------
module hazard_sb_stage
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bubble,
  input  sb_flags_t        d_flags,
  input  logic [REG_W-1:0] d_dest,
  output sb_flags_t        q_flags,
  output logic [REG_W-1:0] q_dest
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q_flags <= '0;
      q_dest  <= '0;
    end else begin
      q_flags <= d_flags;
      q_dest  <= d_dest;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Hazard controller for the 5-stage core. Tracks destinations of in-flight
//   instructions in an EX->MEM->WB scoreboard, produces registered EX operand
//   mux selects, a load-use / jr stall and an IF/ID flush strobe.
//
//   Build option: HAZ_FORWARD_EN
//     defined   : operands are forwarded from MEM/WB; only load-use and jr
//                 hazards stall.
//     undefined : selects stay at FWD_REG and any pending write to a used
//                 source in EX or MEM stalls (full interlock).
//
//   Ports:
//     clk, reset            : core clock, synchronous active-high reset
//     id_valid              : ID holds a real instruction
//     id_rs, id_rt          : ID source registers
//     id_use_rs, id_use_rt  : instruction actually reads rs / rt
//     id_dest, id_regwrite  : destination and write enable (dest ignored on jal)
//     id_memread            : instruction is a load
//     id_jal, id_jr         : jal (writes LINK_REG) / jr (reads rs in ID)
//     ex_branch_taken       : branch in EX resolved taken
//     fwd_a_sel, fwd_b_sel  : registered EX operand mux selects
//     stall                 : hold PC and IF/ID, bubble into ID/EX
//     flush_id              : squash the IF/ID instruction
//
//   Handshake: there is no valid/ready pair here; stall acts as the ready of
//   the ID stage. An ID instruction is accepted on a rising edge where
//   id_valid=1 and stall=0 and ex_branch_taken=0; otherwise the EX entry
//   becomes a bubble and ID must present the same instruction again.
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_jal,
  input  logic             id_jr,
  input  logic             ex_branch_taken,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             flush_id
);

  localparam logic [REG_W-1:0] LINK_IDX = REG_W'(LINK_REG);

  sb_flags_t        id_flags;
  logic [REG_W-1:0] id_dest_eff;
  sb_flags_t        ex_f, mem_f, wb_f;
  logic [REG_W-1:0] ex_dest, mem_dest, wb_dest;

  logic m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt;
  logic load_use, jr_stall, dep_stall, bubble;
  logic [1:0] sel_a_d, sel_b_d;

  // jal always writes the link register regardless of the decoded dest.
  assign id_dest_eff       = id_jal ? LINK_IDX : id_dest;
  assign id_flags.valid    = id_valid;
  assign id_flags.regwrite = id_valid & (id_regwrite | id_jal);
  assign id_flags.memread  = id_valid & id_memread & ~id_jal;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  assign m_ex_rs  = ex_f.valid  & ex_f.regwrite  & (ex_dest  == id_rs) & (id_rs != '0);
  assign m_ex_rt  = ex_f.valid  & ex_f.regwrite  & (ex_dest  == id_rt) & (id_rt != '0);
  assign m_mem_rs = mem_f.valid & mem_f.regwrite & (mem_dest == id_rs) & (id_rs != '0);
  assign m_mem_rt = mem_f.valid & mem_f.regwrite & (mem_dest == id_rt) & (id_rt != '0);

  // A load's data is only available at the end of MEM, one cycle too late
  // for a consumer directly behind it.
  assign load_use = id_valid & ex_f.memread &
                    ((m_ex_rs & id_use_rs) | (m_ex_rt & id_use_rt));

  // jr consumes rs in ID, so it can only take a value already produced at
  // the end of EX (ALU result in MEM); anything younger, or a load in MEM,
  // is not ready yet.
  assign jr_stall = id_valid & id_jr & (m_ex_rs | (m_mem_rs & mem_f.memread));

  always_comb begin
    sel_a_d   = FWD_REG;
    sel_b_d   = FWD_REG;
    dep_stall = 1'b0;
`ifdef HAZ_FORWARD_EN
    if (id_valid) begin
      sel_a_d = fwd_pick(m_ex_rs, m_mem_rs);
      sel_b_d = fwd_pick(m_ex_rt, m_mem_rt);
    end
`else
    dep_stall = id_valid & ((id_use_rs & (m_ex_rs | m_mem_rs)) |
                            (id_use_rt & (m_ex_rt | m_mem_rt)));
`endif
  end

  // A taken branch squashes the ID instruction, so any hazard it had is moot.
  assign stall    = ~reset & ~ex_branch_taken & (load_use | jr_stall | dep_stall);
  assign flush_id = ~reset & ex_branch_taken;
  assign bubble   = stall | ex_branch_taken;

  hazard_sb_stage #(.REG_W(REG_W)) u_sb_ex (
    .clk     (clk),
    .reset   (reset),
    .bubble  (bubble),
    .d_flags (id_flags),
    .d_dest  (id_dest_eff),
    .q_flags (ex_f),
    .q_dest  (ex_dest)
  );

  hazard_sb_stage #(.REG_W(REG_W)) u_sb_mem (
    .clk     (clk),
    .reset   (reset),
    .bubble  (1'b0),
    .d_flags (ex_f),
    .d_dest  (ex_dest),
    .q_flags (mem_f),
    .q_dest  (mem_dest)
  );

  hazard_sb_stage #(.REG_W(REG_W)) u_sb_wb (
    .clk     (clk),
    .reset   (reset),
    .bubble  (1'b0),
    .d_flags (mem_f),
    .d_dest  (mem_dest),
    .q_flags (wb_f),
    .q_dest  (wb_dest)
  );

  // WB-to-ID hazards are absorbed by the write-first register file; the WB
  // entry is tracked only so the chain mirrors the pipeline.
  logic unused_wb;
  assign unused_wb = ^{wb_f, wb_dest};

  // Selects travel into EX together with the instruction they belong to.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      fwd_a_sel <= FWD_REG;
      fwd_b_sel <= FWD_REG;
    end else begin
      fwd_a_sel <= sel_a_d;
      fwd_b_sel <= sel_b_d;
    end
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB), including jal/jr support.
- Tracks destination registers of in-flight instructions in its own ID→EX→MEM→WB scoreboard shift chain.
- Produces the registered 2-bit selects for the EX-stage 3:1 operand muxes, plus pipeline stall and flush strobes.
- Sits beside the ID/EX pipeline register and is clocked in lockstep with it.

Parameters:
- REG_W, 5, register-index width.
- LINK_REG, 31, destination register written by jal.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_W  ID source register A.
- id_rt  in  REG_W  ID source register B.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_dest  in  REG_W  ID destination (rd/rt; ignored when id_jal=1).
- id_regwrite  in  1  instruction writes a register.
- id_memread  in  1  instruction is a load.
- id_jal  in  1  jal: destination forced to LINK_REG.
- id_jr  in  1  jr: rs consumed in ID.
- ex_branch_taken  in  1  branch resolved taken in EX.
- fwd_a_sel  out  2  EX operand-A mux select: 00 regfile, 01 WB result, 10 MEM result.
- fwd_b_sel  out  2  EX operand-B mux select, same encoding.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- flush_id  out  1  squash the IF/ID instruction.

Behaviour:
- Scoreboard: per stage EX/MEM/WB keeps {valid, dest, regwrite, memread}; shifts each clock. Entry with dest==0 never matches.
- Match(stage, r) = valid & regwrite & (dest==r) & (r!=0).
- Forward select is computed in ID and registered into EX with the instruction (1-cycle latency):
  - 10 if Match(EX, rs), i.e. the producer will be in MEM when the consumer is in EX.
  - else 01 if Match(MEM, rs).
  - else 00.
  - The younger producer wins when both match. rt is handled identically for fwd_b_sel.
- WB-stage producer versus ID reader: resolved by the write-first regfile; no action here.
- Load-use (combinational stall): id_valid & EX.memread & (Match(EX,rs)&id_use_rs | Match(EX,rt)&id_use_rt).
- jr interlock (combinational stall): id_jr & (Match(EX,rs) | (Match(MEM,rs) & MEM.memread)).
- While stall=1: the EX entry loads a bubble (valid=0, regwrite=0, sel=00); ID inputs are re-presented next cycle.
- ex_branch_taken=1: flush_id=1, EX loads a bubble, stall forced 0. Flush has priority over stall in the same cycle.
- jal: dest=LINK_REG, regwrite=1, forwarded like any ALU result.
- Reset: all valid bits 0, fwd_a_sel=fwd_b_sel=00, stall=0, flush_id=0. Reset mid-stall clears the stall on the next cycle.
- Back-to-back load-use chains stall exactly 1 cycle per dependency; no deadlock.

Optional Feature:
- HAZ_FORWARD_EN defined: forwarding as specified above.
- Undefined: fwd selects tied to 00. Any Match(EX|MEM, used source) stalls (full interlock), giving up to 2 stall cycles per dependency.

Decomposition:
- Shared package/header: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 constants; the scoreboard entry struct/field widths.
- One sub-module: hazard_sb_stage, a single scoreboard stage register with bubble/flush insertion, instanced 3×.

Test Plan:
- add $3 then sub $4,$3,$5 back-to-back → fwd_a_sel=10 in the sub's EX cycle; stall never asserts.
- add $3, nop, or $6,$7,$3 → fwd_b_sel=01; add $3 followed by add $3 then use $3 → select 10 (youngest producer wins).
- lw $2 then add $4,$2,$2 → stall=1 for exactly 1 cycle, then fwd_a_sel=fwd_b_sel=01.
- Producer writes $0, consumer reads $0 → selects 00, stall 0; jal then jr $31 → stall 1 cycle, jr sees forwarded LINK_REG.
- ex_branch_taken together with a load-use condition → flush_id=1, stall=0, EX bubble (sel 00) next cycle.
- reset asserted during stall → next cycle stall=0 and all selects 00; repeat the load-use test with HAZ_FORWARD_EN undefined → 2-cycle stall.
